// File: rtl/cmd_dispatch.sv
// cmd_dispatch: host command FIFO feeding the CCU one cmd per clock.
// Inserts NOP when empty, stalled, or running an in-band WAIT delay.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   in_cmd      : command byte from host
//   in_valid    : in_cmd valid
//   in_ready    : FIFO not full (combinational)
//   stall       : hold issue, drive NOP
//   cmd         : registered command to CCU
//   cmd_valid   : cmd is a real popped command
//   fifo_count  : entries stored
//   busy        : not idle in RUN, or FIFO non-empty
module cmd_dispatch #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  NOP_CMD  = 8'h00,
  parameter logic [7:0]  WAIT_CMD = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_cmd,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     stall,
  output logic [7:0]               cmd,
  output logic                     cmd_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_ARG = 2'd1,
    DELAY    = 2'd2
  } state_t;

  state_t state;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    delay_cnt;
  logic [7:0]    head;
  logic          push;
  logic          pop;
  logic          issue_ok;

  // Full means not ready, even if a pop
  // would free a slot this same cycle.
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;

  // Pops use the registered count, so a
  // byte pushed into an empty FIFO waits
  // at least one edge before issuing.
  assign issue_ok = (state == RUN) ||
                    (state == WAIT_ARG);
  assign pop      = (count != '0) &&
                    !stall && issue_ok;

  assign head       = mem[rd_ptr];
  assign fifo_count = count;
  assign busy       = (state != RUN) ||
                      (count != '0);

  // Storage is deliberately left uncleared
  // by reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Issue FSM. cmd defaults to NOP each
  // cycle; only a non-WAIT pop in RUN
  // forwards a real command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      delay_cnt <= '0;
      cmd       <= NOP_CMD;
      cmd_valid <= 1'b0;
    end else begin
      cmd       <= NOP_CMD;
      cmd_valid <= 1'b0;
      unique case (state)
        RUN: begin
          if (pop) begin
            if (head == WAIT_CMD) begin
              state <= WAIT_ARG;
            end else begin
              cmd       <= head;
              cmd_valid <= 1'b1;
            end
          end
        end
        WAIT_ARG: begin
          // Argument is a plain count,
          // even when it equals WAIT_CMD.
          if (pop) begin
            if (head == 8'h00) begin
              state <= RUN;
            end else begin
              delay_cnt <= head;
              state     <= DELAY;
            end
          end
        end
        DELAY: begin
          // Counts down regardless of
          // stall; exits after N cycles.
          delay_cnt <= delay_cnt - 8'd1;
          if (delay_cnt == 8'd1) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
